// File: rtl/mfp_adc_max10_model.sv
// mfp_adc_max10_model
//
// Behavioural stand-in for the MAX10 Modular ADC hard block. It accepts
// commands on the command stream, waits a fixed conversion time, and returns
// one result per command. Data comes from a parallel sample bus, which lets a
// testbench or board logic supply the "analog" values.
//
// Command handshake: a command transfers at a rising CLK edge where both
// ADC_C_Valid and ADC_C_Ready are high. ADC_C_Ready depends only on internal
// state, never on ADC_C_Valid. Command fields are sampled only on a transfer.
// The response stream has no ready: ADC_R_Valid is a one-cycle pulse that the
// consumer must take when it appears.
//
// Sample bus layout (12 bits per slice):
//   [11:0]  channel 1  ...  [71:60] channel 6
//   [83:72] channel 17 (temperature)
// Any other channel still produces a response, with data 12'h000.
//
// CONV_CYCLES must be at least 1.

module mfp_adc_max10_model #(
  parameter int CONV_CYCLES = 20
) (
  input  logic        CLK,
  input  logic        RESETn,

  input  logic        ADC_C_Valid,
  input  logic [4:0]  ADC_C_Channel,
  input  logic        ADC_C_SOP,
  input  logic        ADC_C_EOP,
  output logic        ADC_C_Ready,

  output logic        ADC_R_Valid,
  output logic [4:0]  ADC_R_Channel,
  output logic [11:0] ADC_R_Data,
  output logic        ADC_R_SOP,
  output logic        ADC_R_EOP,

  input  logic [83:0] ANALOG_IN,

  output logic [1:0]  dbg_state
);

  // Converter states.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Counter is wide enough to hold CONV_CYCLES, so the load value always fits
  // and the count never wraps.
  localparam int                CNT_W    = $clog2(CONV_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(CONV_CYCLES - 1);

  // Pending command register. It holds one command that is waiting for the converter.
  logic        pend_valid;
  logic [4:0]  pend_channel;
  logic        pend_sop;
  logic        pend_eop;

  // Converter state and the command it is working on.
  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       conv_channel;
  logic [11:0]      conv_data;
  logic             conv_sop;
  logic             conv_eop;

  logic        cmd_fire;
  logic        start;
  logic [11:0] sample_sel;

  // Ready depends only on the pending slot, so a command is never lost.
  assign ADC_C_Ready = ~pend_valid;
  assign cmd_fire    = ADC_C_Valid & ~pend_valid;

  // A conversion starts when a command is pending and the converter is not
  // counting. The converter can start directly from the response cycle, which
  // gives back-to-back throughput of one result every CONV_CYCLES+1 clocks.
  assign start = pend_valid & ((state == S_IDLE) | (state == S_RESP));

  assign dbg_state = state;

  // Pending slot: fill on handshake, drain when the converter takes the command.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      pend_valid   <= 1'b0;
      pend_channel <= 5'd0;
      pend_sop     <= 1'b0;
      pend_eop     <= 1'b0;
    end else if (cmd_fire) begin
      pend_valid   <= 1'b1;
      pend_channel <= ADC_C_Channel;
      pend_sop     <= ADC_C_SOP;
      pend_eop     <= ADC_C_EOP;
    end else if (start) begin
      pend_valid   <= 1'b0;
    end
  end

  // Select the sample slice for the pending command's channel.
  always_comb begin
    sample_sel = 12'h000;
    case (pend_channel)
      5'd1:    sample_sel = ANALOG_IN[11:0];
      5'd2:    sample_sel = ANALOG_IN[23:12];
      5'd3:    sample_sel = ANALOG_IN[35:24];
      5'd4:    sample_sel = ANALOG_IN[47:36];
      5'd5:    sample_sel = ANALOG_IN[59:48];
      5'd6:    sample_sel = ANALOG_IN[71:60];
      5'd17:   sample_sel = ANALOG_IN[83:72];
      default: sample_sel = 12'h000;
    endcase
  end

  // Next-state logic for the converter.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (pend_valid) state_next = S_CONV;
      S_CONV:  if (cnt == '0) state_next = S_RESP;
      S_RESP:  state_next = pend_valid ? S_CONV : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Converter: advance the state, sample-and-hold on start, and count down.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state        <= S_IDLE;
      cnt          <= '0;
      conv_channel <= 5'd0;
      conv_data    <= 12'h000;
      conv_sop     <= 1'b0;
      conv_eop     <= 1'b0;
    end else begin
      state <= state_next;
      if (start) begin
        cnt          <= CNT_LOAD;
        conv_channel <= pend_channel;
        conv_data    <= sample_sel;
        conv_sop     <= pend_sop;
        conv_eop     <= pend_eop;
      end else if ((state == S_CONV) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // Response registers. They are loaded from the next state, so they are
  // high exactly while the converter sits in S_RESP and zero at all other times.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      ADC_R_Valid   <= 1'b0;
      ADC_R_Channel <= 5'd0;
      ADC_R_Data    <= 12'h000;
      ADC_R_SOP     <= 1'b0;
      ADC_R_EOP     <= 1'b0;
    end else if (state_next == S_RESP) begin
      ADC_R_Valid   <= 1'b1;
      ADC_R_Channel <= conv_channel;
      ADC_R_Data    <= conv_data;
      ADC_R_SOP     <= conv_sop;
      ADC_R_EOP     <= conv_eop;
    end else begin
      ADC_R_Valid   <= 1'b0;
      ADC_R_Channel <= 5'd0;
      ADC_R_Data    <= 12'h000;
      ADC_R_SOP     <= 1'b0;
      ADC_R_EOP     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mfp_adc_max10_model.sv
// tb_mfp_adc_max10_model
//
// Directed scenarios followed by a randomized phase. A timing-level reference
// model, built from handshake edges and start/response edge arithmetic,
// predicts ADC_C_Ready and every response. The checker compares these
// predictions with the DUT on each falling edge.

module tb_mfp_adc_max10_model;

  localparam int CC = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        c_valid = 1'b0;
  logic [4:0]  c_ch = 5'd0;
  logic        c_sop = 1'b0;
  logic        c_eop = 1'b0;
  logic [83:0] analog = '0;

  logic        c_ready;
  logic        r_valid;
  logic [4:0]  r_ch;
  logic [11:0] r_data;
  logic        r_sop;
  logic        r_eop;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  mfp_adc_max10_model #(.CONV_CYCLES(CC)) dut (
    .CLK           (clk),
    .RESETn        (rst_n),
    .ADC_C_Valid   (c_valid),
    .ADC_C_Channel (c_ch),
    .ADC_C_SOP     (c_sop),
    .ADC_C_EOP     (c_eop),
    .ADC_C_Ready   (c_ready),
    .ADC_R_Valid   (r_valid),
    .ADC_R_Channel (r_ch),
    .ADC_R_Data    (r_data),
    .ADC_R_SOP     (r_sop),
    .ADC_R_EOP     (r_eop),
    .ANALOG_IN     (analog),
    .dbg_state     (dbg_state)
  );

  // ---------------- check counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Return the value the ADC should report for a channel, given a sample-bus snapshot.
  function automatic logic [11:0] ref_sample(input logic [4:0] ch, input logic [83:0] a);
    if (ch >= 5'd1 && ch <= 5'd6) return a[(int'(ch) - 1) * 12 +: 12];
    if (ch == 5'd17) return a[83:72];
    return 12'h000;
  endfunction

  // ---------------- reference model ----------------
  // cyc counts rising edges. A command accepted at edge a starts converting at
  // the first edge s >= m_free with s > a, and it responds at edge s+CC.
  // After that response, the converter can start again at edge s+CC+1.
  int          cyc = 0;
  bit          m_pend = 1'b0;
  logic [4:0]  m_ch = 5'd0;
  logic        m_sop = 1'b0;
  logic        m_eop = 1'b0;
  int          m_free = 0;
  int          m_acc_cnt = 0;
  int          m_acc_edge = 0;
  logic [18:0] exp_q[$];       // {channel, data, sop, eop}
  int          exp_edge_q[$];  // edge after which the response is valid

  always @(posedge clk) begin
    bit rdy;
    cyc++;
    if (!rst_n) begin
      m_pend = 1'b0;
      m_free = 0;
      exp_q.delete();
      exp_edge_q.delete();
    end else begin
      rdy = !m_pend;
      if (m_pend && cyc >= m_free) begin
        exp_q.push_back({m_ch, ref_sample(m_ch, analog), m_sop, m_eop});
        exp_edge_q.push_back(cyc + CC);
        m_free = cyc + CC + 1;
        m_pend = 1'b0;
      end
      if (c_valid && rdy) begin
        m_pend     = 1'b1;
        m_ch       = c_ch;
        m_sop      = c_sop;
        m_eop      = c_eop;
        m_acc_cnt++;
        m_acc_edge = cyc;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  int          resp_cyc_q[$];
  logic [4:0]  resp_ch_q[$];
  logic [11:0] resp_data_q[$];
  logic [1:0]  resp_se_q[$];

  always @(negedge clk) begin
    logic [18:0] exp_r;
    bit          exp_v;
    exp_r = '0;
    exp_v = 1'b0;
    if (exp_edge_q.size() > 0 && exp_edge_q[0] == cyc) begin
      exp_v = 1'b1;
      exp_r = exp_q.pop_front();
      void'(exp_edge_q.pop_front());
    end
    chk("c_ready", 32'(c_ready), 32'(!m_pend));
    chk("r_valid", 32'(r_valid), 32'(exp_v));
    chk("r_fields", 32'({r_ch, r_data, r_sop, r_eop}), 32'(exp_r));
    if (r_valid) begin
      resp_cyc_q.push_back(cyc);
      resp_ch_q.push_back(r_ch);
      resp_data_q.push_back(r_data);
      resp_se_q.push_back({r_sop, r_eop});
    end
  end

  task automatic clear_log();
    resp_cyc_q.delete();
    resp_ch_q.delete();
    resp_data_q.delete();
    resp_se_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [4:0] ch, input logic sop, input logic eop,
                      input bit hold, output int edge_no);
    int n0;
    n0      = m_acc_cnt;
    edge_no = -1;
    c_valid = 1'b1;
    c_ch    = ch;
    c_sop   = sop;
    c_eop   = eop;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (m_acc_cnt != n0) begin
        edge_no = m_acc_edge;
        break;
      end
    end
    chk("send_accepted", 32'(edge_no >= 0), 32'd1);
    if (!hold) c_valid = 1'b0;
  endtask

  task automatic wait_resp(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (resp_cyc_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    chk("resp_arrived", 32'(ok), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int e0, e1, e2;
    bit ok;

    // Reset for two cycles, then stay idle.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_ready", 32'(c_ready), 32'd1);
    chk("reset_r_out", 32'({r_valid, r_ch, r_data, r_sop, r_eop}), 32'd0);
    repeat (50) @(posedge clk);
    #1;
    chk("idle_no_resp", 32'(resp_cyc_q.size()), 32'd0);

    // Single conversion on channel 1.
    clear_log();
    analog[11:0] = 12'h123;
    send(5'd1, 1'b1, 1'b1, 1'b0, e0);
    chk("hs_ready_low", 32'(c_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("ready_back", 32'(c_ready), 32'd1);
    wait_resp(1, ok);
    if (ok) begin
      chk("single_latency", 32'(resp_cyc_q[0] - e0), 32'(CC + 1));
      chk("single_ch", 32'(resp_ch_q[0]), 32'd1);
      chk("single_data", 32'(resp_data_q[0]), 32'h123);
      chk("single_sopeop", 32'(resp_se_q[0]), 32'd3);
    end

    // Sample-and-hold: a change after the start edge must not affect the result.
    clear_log();
    analog[83:72] = 12'hABC;
    send(5'd17, 1'b1, 1'b1, 1'b0, e0);
    @(posedge clk);
    #1 analog[83:72] = 12'h555;
    wait_resp(1, ok);
    if (ok) begin
      chk("sh_ch", 32'(resp_ch_q[0]), 32'd17);
      chk("sh_data", 32'(resp_data_q[0]), 32'hABC);
    end

    // Back-to-back with ADC_C_Valid held high.
    repeat (3) @(posedge clk);
    clear_log();
    analog[11:0]  = 12'h111;
    analog[23:12] = 12'h222;
    analog[83:72] = 12'h777;
    send(5'd1, 1'b1, 1'b0, 1'b1, e0);
    send(5'd2, 1'b0, 1'b0, 1'b1, e1);
    send(5'd17, 1'b0, 1'b1, 1'b0, e2);
    chk("b2b_hs2", 32'(e1 - e0), 32'd2);
    chk("b2b_hs3", 32'(e2 - e0), 32'(CC + 3));
    wait_resp(3, ok);
    if (ok) begin
      chk("b2b_lat0", 32'(resp_cyc_q[0] - e0), 32'(CC + 1));
      chk("b2b_gap1", 32'(resp_cyc_q[1] - resp_cyc_q[0]), 32'(CC + 1));
      chk("b2b_gap2", 32'(resp_cyc_q[2] - resp_cyc_q[1]), 32'(CC + 1));
      chk("b2b_ch", 32'({resp_ch_q[0], resp_ch_q[1], resp_ch_q[2]}), 32'({5'd1, 5'd2, 5'd17}));
      chk("b2b_data0", 32'(resp_data_q[0]), 32'h111);
      chk("b2b_data1", 32'(resp_data_q[1]), 32'h222);
      chk("b2b_data2", 32'(resp_data_q[2]), 32'h777);
      chk("b2b_sopeop", 32'({resp_se_q[0], resp_se_q[1], resp_se_q[2]}), 32'b10_00_01);
    end

    // Unsupported channel.
    repeat (3) @(posedge clk);
    clear_log();
    analog = {84{1'b1}};
    send(5'd9, 1'b1, 1'b1, 1'b0, e0);
    wait_resp(1, ok);
    if (ok) begin
      chk("ch9_latency", 32'(resp_cyc_q[0] - e0), 32'(CC + 1));
      chk("ch9_ch", 32'(resp_ch_q[0]), 32'd9);
      chk("ch9_data", 32'(resp_data_q[0]), 32'h000);
    end

    // Reset mid-conversion, with one command pending.
    repeat (3) @(posedge clk);
    send(5'd3, 1'b1, 1'b0, 1'b1, e0);
    send(5'd4, 1'b0, 1'b1, 1'b0, e1);
    chk("mid_pending", 32'(c_ready), 32'd0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("mid_reset_ready", 32'(c_ready), 32'd1);
    clear_log();
    repeat (20) @(posedge clk);
    #1;
    chk("mid_no_resp", 32'(resp_cyc_q.size()), 32'd0);
    analog[59:48] = 12'h5A5;
    send(5'd5, 1'b1, 1'b1, 1'b0, e0);
    wait_resp(1, ok);
    if (ok) begin
      chk("post_rst_latency", 32'(resp_cyc_q[0] - e0), 32'(CC + 1));
      chk("post_rst_data", 32'(resp_data_q[0]), 32'h5A5);
    end

    // Randomized phase. The model checks every cycle.
    for (int i = 0; i < 2500; i++) begin
      int r;
      @(posedge clk);
      #1;
      c_valid = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      if (r < 6) c_ch = 5'(r + 1);
      else if (r < 8) c_ch = 5'd17;
      else c_ch = 5'($urandom_range(0, 31));
      c_sop = 1'($urandom_range(0, 1));
      c_eop = 1'($urandom_range(0, 1));
      analog[31:0]  = $urandom;
      analog[63:32] = $urandom;
      analog[83:64] = 20'($urandom);
      rst_n = ($urandom_range(0, 599) != 0);
    end
    c_valid = 1'b0;
    rst_n   = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mfp_adc_max10_model.md
# mfp_adc_max10_model

Synthesizable responder for the MAX10 Modular ADC command/response streams. It accepts conversion commands exactly as the hard ADC block does and returns one result per command after a fixed conversion latency, with data taken from a parallel sample bus. It drops in where the hard ADC IP sits, under the AHB-Lite ADC controller, for simulation and for boards or builds without the ADC IP.

## Interface
- CONV_CYCLES, 20: conversion length in clocks; legal range >= 1.
- CLK  in  1  clock.
- RESETn  in  1  reset. Synchronous, active-low.
- ADC_C_Valid  in  1  command valid.
- ADC_C_Channel  in  5  command channel.
- ADC_C_SOP  in  1  command start of packet.
- ADC_C_EOP  in  1  command end of packet.
- ADC_C_Ready  out  1  command ready.
- ADC_R_Valid  out  1  response valid. Single-cycle pulse, no backpressure.
- ADC_R_Channel  out  5  response channel.
- ADC_R_Data  out  12  conversion result.
- ADC_R_SOP  out  1  response start of packet.
- ADC_R_EOP  out  1  response end of packet.
- ANALOG_IN  in  84  sample bus, 12-bit slices:
  - [11:0] channel 1 through [71:60] channel 6.
  - [83:72] channel 17 (temperature).

## Operation
- Pending register: one entry holding channel, SOP and EOP, plus pend_valid.
  - ADC_C_Ready = ~pend_valid (combinational).
  - Handshake is ADC_C_Valid & ADC_C_Ready at a rising edge; it loads the pending register and sets pend_valid.
- Converter FSM, states S_IDLE, S_CONV, S_RESP:
  - S_IDLE: if pend_valid, go to S_CONV. On that transition:
    - load cnt = CONV_CYCLES-1;
    - latch channel, SOP and EOP;
    - latch the ANALOG_IN slice for the channel (sample-and-hold);
    - clear pend_valid.
  - S_CONV: if cnt == 0, go to S_RESP; otherwise decrement cnt.
  - S_RESP: if pend_valid, go to S_CONV with the same load/latch/clear actions as S_IDLE; otherwise go to S_IDLE.
- Counter width: $clog2(CONV_CYCLES+1). It never wraps.
- Channel map: 1..6 select slices 0..5; 17 selects slice 6. Any other channel returns data 12'h000 and still produces a response carrying its channel number.
- Response outputs are registered.
  - In S_RESP: ADC_R_Valid=1 with the latched channel, data, SOP and EOP.
  - In every other state: all ADC_R_* outputs are 0.
- SOP/EOP are copied from command to response only. The model performs no packet-framing checks.
- At most one conversion in flight plus one pending command.

## Timing
- Reset values:
  - ADC_C_Ready=1 (pend_valid=0);
  - ADC_R_Valid=0, ADC_R_Channel=0, ADC_R_Data=0, ADC_R_SOP=0, ADC_R_EOP=0;
  - state S_IDLE, cnt=0.
- Reset mid-conversion or while a command is pending discards all work. No response is issued, and ADC_C_Ready=1 on the first cycle after reset.
- Latency for a command handshaken at edge E0 into an idle model:
  - E0+1: conversion start, sample latched; ADC_C_Ready returns to 1 after E0+1.
  - ADC_R_Valid is high for exactly the one cycle following edge E0+CONV_CYCLES+1.
- ADC_C_Ready is low for exactly one cycle after each handshake into an idle converter. It stays low while a command waits behind an active conversion.
- Back-to-back throughput: one response every CONV_CYCLES+1 cycles.
- ANALOG_IN changes after the start edge do not affect the result.
- Holding ADC_C_Valid without a handshake has no effect. Command fields are sampled only at a handshake.

## Test plan
- Reset: assert RESETn=0 for 2 cycles -> ADC_C_Ready=1 and all ADC_R_* = 0; no response for 50 cycles with ADC_C_Valid=0.
- Single conversion, CONV_CYCLES=4: ANALOG_IN[11:0]=12'h123, send ch1 with SOP=EOP=1 at E0 -> one-cycle ADC_R_Valid after E5 with Channel=1, Data=12'h123, SOP=EOP=1; ADC_C_Ready low only during cycle E0..E1.
- Sample-and-hold: ANALOG_IN[83:72]=12'hABC at start edge, changed to 12'h555 one cycle later, ch17 -> Data=12'hABC.
- Back-to-back: ADC_C_Valid held with channels 1, 2, 17 (SOP on first, EOP on last), CONV_CYCLES=4 -> responses spaced 5 cycles apart in order 1, 2, 17; SOP only on first, EOP only on last; second handshake at E1+1, third after the first response.
- Unsupported channel 9 -> response Channel=9, Data=12'h000, after the normal latency.
- Reset mid-operation: RESETn low at cnt=2 with one command pending -> no ADC_R_Valid afterwards; next command after reset completes with normal latency.
